// File: rtl/carregador_limites_temperatura_pkg.sv
// carregador_limites_temperatura_pkg: shared state encoding, error codes and frame constants
//  Exports: estado_t (ESPERA, RECEBE, CHECA, APLICA), ERR_* error codes, CABECALHO_PADRAO.
package carregador_limites_temperatura_pkg;
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        RECEBE = 2'd1,
        CHECA  = 2'd2,
        APLICA = 2'd3
    } estado_t;
    localparam logic [1:0] ERR_NENHUM   = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_ORDEM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
    localparam logic [7:0] CABECALHO_PADRAO = 8'hA5;
    localparam int         BYTES_DADOS      = 8;
endpackage

// File: rtl/carregador_limites_temperatura_if.sv
// carregador_limites_temperatura_if: byte stream from the serial receiver to the threshold loader
//  dado_byte   8  received byte
//  dado_valido 1  one-cycle strobe, dado_byte valid this cycle (no backpressure)
//  master: serial receiver side; slave: loader side.
interface carregador_limites_temperatura_if;
    logic [7:0] dado_byte;
    logic       dado_valido;
    modport master (output dado_byte, output dado_valido);
    modport slave  (input  dado_byte, input  dado_valido);
endinterface

// File: rtl/comparador_n.sv
// comparador_n: unsigned N-bit magnitude comparator
//  a, b   in  N  operands
//  menor  out 1  a < b
//  igual  out 1  a == b
module comparador_n #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         menor,
    output logic         igual
);
    assign menor = a < b;
    assign igual = a == b;
endmodule

// File: rtl/carregador_limites_temperatura.sv
// carregador_limites_temperatura: assembles framed bytes into four thresholds and commits them atomically
//  clock, reset        clock (rising edge) and synchronous active-high reset
//  rx                  byte stream (slave modport of carregador_limites_temperatura_if)
//  lim_temp1..4        committed thresholds, registered
//  atualizado, erro    one-cycle pulses on commit / rejection
//  erro_codigo         last error: 00 none, 01 checksum, 10 order, 11 timeout
//  ocupado             high while a frame is being handled
//  Build option: define CARREGADOR_VERIFICA_ORDEM_EN to require lim1<=lim2<=lim3<=lim4 before commit.
module carregador_limites_temperatura
    import carregador_limites_temperatura_pkg::*;
#(
    parameter int           N         = 16,
    parameter logic [7:0]   CABECALHO = CABECALHO_PADRAO,
    parameter int           TIMEOUT   = 1000000,
    parameter logic [N-1:0] LIM1_RST  = N'(400),
    parameter logic [N-1:0] LIM2_RST  = N'(500),
    parameter logic [N-1:0] LIM3_RST  = N'(600),
    parameter logic [N-1:0] LIM4_RST  = N'(700)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    carregador_limites_temperatura_if.slave      rx,
    output logic [N-1:0]                         lim_temp1,
    output logic [N-1:0]                         lim_temp2,
    output logic [N-1:0]                         lim_temp3,
    output logic [N-1:0]                         lim_temp4,
    output logic                                 atualizado,
    output logic                                 erro,
    output logic [1:0]                           erro_codigo,
    output logic                                 ocupado
);
    localparam int TW = $clog2(TIMEOUT + 1);

    estado_t          estado_q, estado_d;
    logic [2:0]       idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [4*N-1:0]   stg_q, stg_d;
    logic [7:0]       xor_q, xor_d;
    logic             ok_q, ok_d;
    logic [N-1:0]     lim1_q, lim1_d, lim2_q, lim2_d, lim3_q, lim3_d, lim4_q, lim4_d;
    logic             atualizado_q, atualizado_d, erro_q, erro_d;
    logic [1:0]       codigo_q, codigo_d;
    logic             ordem_ok;

    // Staged thresholds; lim1 arrives first so it ends up in the top bits.
    logic [N-1:0] s1, s2, s3, s4;
    assign s1 = stg_q[4*N-1 -: N];
    assign s2 = stg_q[3*N-1 -: N];
    assign s3 = stg_q[2*N-1 -: N];
    assign s4 = stg_q[N-1 -: N];

`ifdef CARREGADOR_VERIFICA_ORDEM_EN
    logic m12, i12, m23, i23, m34, i34;
    comparador_n #(.N(N)) u_cmp12 (.a(s1), .b(s2), .menor(m12), .igual(i12));
    comparador_n #(.N(N)) u_cmp23 (.a(s2), .b(s3), .menor(m23), .igual(i23));
    comparador_n #(.N(N)) u_cmp34 (.a(s3), .b(s4), .menor(m34), .igual(i34));
    assign ordem_ok = (m12 | i12) & (m23 | i23) & (m34 | i34);
`else
    assign ordem_ok = 1'b1;
`endif

    always_comb begin
        estado_d     = estado_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        stg_d        = stg_q;
        xor_d        = xor_q;
        ok_d         = ok_q;
        lim1_d       = lim1_q;
        lim2_d       = lim2_q;
        lim3_d       = lim3_q;
        lim4_d       = lim4_q;
        atualizado_d = 1'b0;
        erro_d       = 1'b0;
        codigo_d     = codigo_q;
        case (estado_q)
            ESPERA: begin
                if (rx.dado_valido && rx.dado_byte == CABECALHO) begin
                    estado_d = RECEBE;
                    idx_d    = '0;
                    timer_d  = '0;
                    xor_d    = '0;
                end
            end
            RECEBE, CHECA: begin
                if (rx.dado_valido) begin
                    timer_d = '0;
                    if (estado_q == RECEBE) begin
                        // A header value here is just data: no resynchronisation mid-frame.
                        stg_d    = {stg_q[4*N-9:0], rx.dado_byte};
                        xor_d    = xor_q ^ rx.dado_byte;
                        idx_d    = idx_q + 3'd1;
                        estado_d = (idx_q == 3'(BYTES_DADOS - 1)) ? CHECA : RECEBE;
                    end else begin
                        ok_d     = rx.dado_byte == xor_q;
                        estado_d = APLICA;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    estado_d = ESPERA;
                    stg_d    = '0;
                    erro_d   = 1'b1;
                    codigo_d = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            APLICA: begin
                // Checksum failure takes priority over an ordering failure.
                estado_d = ESPERA;
                if (!ok_q) begin
                    erro_d   = 1'b1;
                    codigo_d = ERR_CHECKSUM;
                end else if (!ordem_ok) begin
                    erro_d   = 1'b1;
                    codigo_d = ERR_ORDEM;
                end else begin
                    lim1_d       = s1;
                    lim2_d       = s2;
                    lim3_d       = s3;
                    lim4_d       = s4;
                    atualizado_d = 1'b1;
                    codigo_d     = ERR_NENHUM;
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= ESPERA;
            idx_q        <= '0;
            timer_q      <= '0;
            stg_q        <= '0;
            xor_q        <= '0;
            ok_q         <= 1'b0;
            lim1_q       <= LIM1_RST;
            lim2_q       <= LIM2_RST;
            lim3_q       <= LIM3_RST;
            lim4_q       <= LIM4_RST;
            atualizado_q <= 1'b0;
            erro_q       <= 1'b0;
            codigo_q     <= ERR_NENHUM;
        end else begin
            estado_q     <= estado_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            stg_q        <= stg_d;
            xor_q        <= xor_d;
            ok_q         <= ok_d;
            lim1_q       <= lim1_d;
            lim2_q       <= lim2_d;
            lim3_q       <= lim3_d;
            lim4_q       <= lim4_d;
            atualizado_q <= atualizado_d;
            erro_q       <= erro_d;
            codigo_q     <= codigo_d;
        end
    end

    assign lim_temp1   = lim1_q;
    assign lim_temp2   = lim2_q;
    assign lim_temp3   = lim3_q;
    assign lim_temp4   = lim4_q;
    assign atualizado  = atualizado_q;
    assign erro        = erro_q;
    assign erro_codigo = codigo_q;
    assign ocupado     = estado_q != ESPERA;
endmodule
